// File: rtl/fp_pkg.sv
// Shared FP write-back types: register/data widths, source encoding and the
// {rd, data} entry carried by each holding buffer.
package fp_pkg;

  localparam int FP_REG_W  = 5;
  localparam int FP_DATA_W = 32;

  typedef enum logic {
    SRC_FPU = 1'b0,
    SRC_LD  = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [FP_REG_W-1:0]  rd;
    logic [FP_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/fp_wb_slot.sv
// One-entry valid/ready holding buffer for a write-back producer. The slot can
// take new data on the same edge its current entry is granted.
module fp_wb_slot
  import fp_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      in_valid,
  input  wb_entry_t in_entry,
  input  logic      grant,
  output logic      ready,
  output logic      accept,
  output logic      occupied,
  output wb_entry_t entry
);

  assign ready  = ~occupied | grant;
  assign accept = in_valid & ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      occupied <= 1'b0;
    end else if (accept) begin
      occupied <= 1'b1;
    end else if (grant) begin
      occupied <= 1'b0;
    end
  end

  // NOTE: the payload is qualified by occupied, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      entry <= in_entry;
    end
  end

endmodule

// File: rtl/fp_wb_arbiter.sv
// Arbitrates the FPU and FP-load producers onto the single registered FP
// register-file write port (fixed priority, starvation override, same-rd order).
module fp_wb_arbiter
  import fp_pkg::*;
#(
  parameter int LOAD_FIRST = 1,
  parameter int MAX_WAIT   = 4,
  parameter int WAIT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fpu_valid,
  input  logic [FP_REG_W-1:0]  fpu_rd,
  input  logic [FP_DATA_W-1:0] fpu_data,
  output logic                 fpu_ready,
  input  logic                 ld_valid,
  input  logic [FP_REG_W-1:0]  ld_rd,
  input  logic [FP_DATA_W-1:0] ld_data,
  output logic                 ld_ready,
  output logic [FP_REG_W-1:0]  rd_temp_f_wb,
  output logic [FP_DATA_W-1:0] wb_data_f,
  output logic                 reg_write_f_en,
  output logic                 wb_src,
  output logic                 busy
);

  localparam logic LD_HI = (LOAD_FIRST != 0);

  wb_entry_t         fpu_entry, ld_entry;
  logic              fpu_occ, ld_occ;
  logic              fpu_acc, ld_acc;
  logic              fpu_grant, ld_grant;
  logic              ld_older;
  logic [WAIT_W-1:0] wait_cnt;
  logic              starved, lo_occ, lo_grant;

  fp_wb_slot u_fpu_slot (
    .clk      (clk),
    .rst      (rst),
    .in_valid (fpu_valid),
    .in_entry ('{rd: fpu_rd, data: fpu_data}),
    .grant    (fpu_grant),
    .ready    (fpu_ready),
    .accept   (fpu_acc),
    .occupied (fpu_occ),
    .entry    (fpu_entry)
  );

  fp_wb_slot u_ld_slot (
    .clk      (clk),
    .rst      (rst),
    .in_valid (ld_valid),
    .in_entry ('{rd: ld_rd, data: ld_data}),
    .grant    (ld_grant),
    .ready    (ld_ready),
    .accept   (ld_acc),
    .occupied (ld_occ),
    .entry    (ld_entry)
  );

  assign starved  = (wait_cnt == WAIT_W'(MAX_WAIT));
  assign lo_occ   = LD_HI ? fpu_occ   : ld_occ;
  assign lo_grant = LD_HI ? fpu_grant : ld_grant;
  assign busy     = fpu_occ | ld_occ;

  // Grant depends on buffer state only, so ready never loops back from valid.
  always_comb begin
    fpu_grant = 1'b0;
    ld_grant  = 1'b0;
    if (fpu_occ && ld_occ) begin
      if (fpu_entry.rd == ld_entry.rd) begin
        ld_grant  = ld_older;
        fpu_grant = ~ld_older;
      end else if (starved) begin
        ld_grant  = ~LD_HI;
        fpu_grant = LD_HI;
      end else begin
        ld_grant  = LD_HI;
        fpu_grant = ~LD_HI;
      end
    end else begin
      fpu_grant = fpu_occ;
      ld_grant  = ld_occ;
    end
  end

  // A fresh entry is always younger than whatever the other slot still holds;
  // on a simultaneous fill the FPU entry counts as older.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_older <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (fpu_acc && ld_acc) begin
        ld_older <= 1'b0;
      end else if (fpu_acc) begin
        ld_older <= 1'b1;
      end else if (ld_acc) begin
        ld_older <= 1'b0;
      end

      if (lo_occ && !lo_grant) begin
        if (!starved) begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_f_en <= 1'b0;
      rd_temp_f_wb   <= '0;
      wb_data_f      <= '0;
      wb_src         <= SRC_FPU;
    end else if (fpu_grant || ld_grant) begin
      reg_write_f_en <= 1'b1;
      rd_temp_f_wb   <= ld_grant ? ld_entry.rd   : fpu_entry.rd;
      wb_data_f      <= ld_grant ? ld_entry.data : fpu_entry.data;
      wb_src         <= ld_grant ? SRC_LD : SRC_FPU;
    end else begin
      reg_write_f_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a sequence-number based model of the two holding buffers.
module tb_fp_wb_arbiter;

  localparam int LOAD_FIRST = 1;
  localparam int MAX_WAIT   = 4;
  localparam int LO         = LOAD_FIRST ? 0 : 1;  // 0 = FPU, 1 = load
  localparam int HI         = 1 - LO;

  logic        clk = 1'b0;
  logic        rst;
  logic        fpu_valid, ld_valid;
  logic [4:0]  fpu_rd, ld_rd;
  logic [31:0] fpu_data, ld_data;
  logic        fpu_ready, ld_ready;
  logic [4:0]  rd_temp_f_wb;
  logic [31:0] wb_data_f;
  logic        reg_write_f_en, wb_src, busy;

  always #5 clk = ~clk;

  fp_wb_arbiter #(
    .LOAD_FIRST (LOAD_FIRST),
    .MAX_WAIT   (MAX_WAIT),
    .WAIT_W     (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fpu_valid      (fpu_valid),
    .fpu_rd         (fpu_rd),
    .fpu_data       (fpu_data),
    .fpu_ready      (fpu_ready),
    .ld_valid       (ld_valid),
    .ld_rd          (ld_rd),
    .ld_data        (ld_data),
    .ld_ready       (ld_ready),
    .rd_temp_f_wb   (rd_temp_f_wb),
    .wb_data_f      (wb_data_f),
    .reg_write_f_en (reg_write_f_en),
    .wb_src         (wb_src),
    .busy           (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Model: each buffer holds an entry stamped with a global fill sequence number.
  bit          m_v[2];
  logic [4:0]  m_rd[2];
  logic [31:0] m_data[2];
  int          m_seq[2];
  int          next_seq;
  int          refused;
  bit          e_en, e_src;
  logic [4:0]  e_rd;
  logic [31:0] e_data;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) m_v[i] = 0;
    refused = 0;
    e_en = 0; e_src = 0; e_rd = '0; e_data = '0;
  endtask

  function automatic int model_grant();
    if (m_v[0] && m_v[1]) begin
      if (m_rd[0] == m_rd[1]) return (m_seq[0] < m_seq[1]) ? 0 : 1;
      if (refused >= MAX_WAIT) return LO;
      return HI;
    end
    if (m_v[0]) return 0;
    if (m_v[1]) return 1;
    return -1;
  endfunction

  task automatic do_cycle(input logic r, input logic fv, input logic [4:0] frd,
                          input logic [31:0] fd, input logic lv,
                          input logic [4:0] lrd, input logic [31:0] ld);
    int g;
    bit rdy[2];
    bit vin[2];
    logic [4:0] rin[2];
    logic [31:0] din[2];
    @(negedge clk);
    rst = r; fpu_valid = fv; fpu_rd = frd; fpu_data = fd;
    ld_valid = lv; ld_rd = lrd; ld_data = ld;
    g = model_grant();
    for (int i = 0; i < 2; i++) rdy[i] = !m_v[i] || (g == i);
    check("fpu_ready", 32'(fpu_ready), 32'(rdy[0]));
    check("ld_ready", 32'(ld_ready), 32'(rdy[1]));
    check("busy", 32'(busy), 32'(m_v[0] || m_v[1]));
    check("wr_en", 32'(reg_write_f_en), 32'(e_en));
    check("wr_rd", 32'(rd_temp_f_wb), 32'(e_rd));
    check("wr_data", wb_data_f, e_data);
    check("wb_src", 32'(wb_src), 32'(e_src));
    if (r) begin
      model_reset();
      return;
    end
    if (m_v[LO] && g != LO) begin
      if (refused < MAX_WAIT) refused++;
    end else begin
      refused = 0;
    end
    if (g >= 0) begin
      e_en = 1; e_rd = m_rd[g]; e_data = m_data[g]; e_src = (g == 1);
      m_v[g] = 0;
    end else begin
      e_en = 0;
    end
    vin[0] = fv; rin[0] = frd; din[0] = fd;
    vin[1] = lv; rin[1] = lrd; din[1] = ld;
    for (int i = 0; i < 2; i++) begin
      if (vin[i] && rdy[i]) begin
        m_v[i] = 1; m_rd[i] = rin[i]; m_data[i] = din[i]; m_seq[i] = next_seq++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    next_seq = 0;
    rst = 1; fpu_valid = 0; ld_valid = 0;
    fpu_rd = 0; ld_rd = 0; fpu_data = 0; ld_data = 0;
    repeat (2) @(posedge clk);
    model_reset();

    // Single FPU write.
    do_cycle(0, 1, 5'd3, 32'h3F80_0000, 0, 0, 0);
    idle(3);
    // Simultaneous, different rd: load wins first.
    do_cycle(0, 1, 5'd1, 32'h1111_1111, 1, 5'd2, 32'h2222_2222);
    idle(3);
    // Same rd: program order (FPU older) beats load priority.
    do_cycle(0, 1, 5'd5, 32'hAAAA_AAAA, 1, 5'd5, 32'hBBBB_BBBB);
    idle(3);
    // Starvation: load streams continuously while an FPU write waits.
    do_cycle(0, 1, 5'd7, 32'h7777_7777, 1, 5'd8, 32'h8000_0000);
    for (int i = 1; i < 9; i++) do_cycle(0, 0, 0, 0, 1, 5'd8, 32'h8000_0000 + i);
    idle(3);
    // Back-to-back load streaming.
    for (int i = 0; i < 8; i++) do_cycle(0, 0, 0, 0, 1, 5'(10 + i), 32'hC000_0000 + i);
    idle(3);
    // Reset with both buffers occupied.
    do_cycle(0, 1, 5'd4, 32'h4444_4444, 1, 5'd6, 32'h6666_6666);
    do_cycle(1, 1, 5'd9, 32'h9999_9999, 1, 5'd9, 32'h9999_9999);
    idle(3);

    // Random traffic with a small rd range to exercise the same-rd rule.
    for (int i = 0; i < 2000; i++) begin
      do_cycle(($urandom_range(0, 99) == 0),
               ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), $urandom,
               ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), $urandom);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_wb_arbiter.md
Name: fp_wb_arbiter

Overview:
- Shares the single FP register-file write port between two producers: FPU results and FP load data returning from memory (flw).
- Each producer has a valid/ready channel feeding a 1-entry holding buffer.
- The arbiter grants one buffer per cycle using fixed priority, a starvation override and a same-rd ordering rule.
- It drives the registered write port consumed by the FP register file, and sits between the FPU/LSU outputs and the FP register file.

Parameters:
- LOAD_FIRST, 1, 1 = load channel has default priority; 0 = FPU channel has default priority.
- MAX_WAIT, 4, cycles the low-priority buffer may be occupied and refused before it is forced to win; range 1..15.
- WAIT_W, 4, width of the starvation counter; must hold MAX_WAIT.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- fpu_valid  input  1  FPU result valid
- fpu_rd  input  5  FPU destination register
- fpu_data  input  32  FPU result
- fpu_ready  output  1  FPU channel can accept
- ld_valid  input  1  FP load data valid
- ld_rd  input  5  load destination register
- ld_data  input  32  load data
- ld_ready  output  1  load channel can accept
- rd_temp_f_wb  output  5  write-port destination
- wb_data_f  output  32  write-port data
- reg_write_f_en  output  1  write-port enable, one cycle per write
- wb_src  output  1  source of the current write: 0 = FPU, 1 = load
- busy  output  1  either buffer occupied

Behaviour:
- Reset:
  - Both buffers empty.
  - Starvation counter 0, age flag 0.
  - reg_write_f_en=0, rd_temp_f_wb=0, wb_data_f=0, wb_src=0, busy=0.
  - Reset mid-operation discards buffered writes; no write issues on the cycle after reset.
- Accept:
  - x_ready = buffer_x empty OR buffer_x granted this cycle. Ready is combinational from state only, never from x_valid.
  - On x_valid && x_ready the buffer loads {rd, data} at the edge.
- Grant, evaluated each cycle over the occupied buffers, highest rule first:
  1. Only one occupied: grant it.
  2. Both occupied with equal rd: grant the older buffer (age flag). This rule overrides 3 and 4, so program order to one register is preserved.
  3. Starvation counter == MAX_WAIT: grant the low-priority buffer.
  4. Otherwise grant the default-priority buffer.
- Age flag:
  - Records which buffer filled first.
  - When both fill on the same edge, FPU is older.
  - When one refills while the other is still occupied, the occupied one is older.
- Starvation counter:
  - Increments when the low-priority buffer is occupied and not granted, saturating at MAX_WAIT.
  - Clears to 0 when the low-priority buffer is granted or empty.
- Output register:
  - On a grant, at the next edge: reg_write_f_en=1, rd_temp_f_wb/wb_data_f take the granted buffer, wb_src takes the source.
  - With no grant: reg_write_f_en=0; rd and data hold their last values.
- Latency and throughput:
  - An uncontested request presented in cycle c is accepted at the end of c and appears on the write port in cycle c+2.
  - Sustained throughput is 1 write/cycle total. The losing channel sees ready=0 until its buffer is granted.
- Simultaneous refill: a granted buffer may accept new data on the same edge. The new entry becomes younger than the other buffer.
- busy = buffer_fpu occupied OR buffer_ld occupied.

Decomposition:
- Shared package fp_pkg:
  - FP_REG_W=5, FP_DATA_W=32.
  - Source encodings SRC_FPU=0, SRC_LD=1.
- Sub-module fp_wb_slot: the 1-entry valid/ready holding buffer. Instantiate it twice; the arbiter logic stays at top level.

Test Plan:
- Reset then single FPU write: fpu_valid=1, rd=3, data=0x3F800000 in cycle 1 → reg_write_f_en=1, rd=3, data=0x3F800000, wb_src=0 in cycle 3. Enable is low in all other cycles.
- Simultaneous different rd, LOAD_FIRST=1: fpu rd=1, ld rd=2 same cycle → load written first, FPU written the next cycle. fpu_ready=0 for exactly one cycle.
- Same-rd ordering: both accepted together with rd=5 (FPU data A, load data B) → A written first then B. Final visible data B, despite load priority.
- Starvation, MAX_WAIT=4: ld_valid held continuously with new data each cycle, FPU request rd=7 pending → FPU granted after exactly 4 refused cycles; counter back to 0.
- Back-to-back streaming: ld_valid=1 for 8 consecutive cycles, FPU idle → 8 consecutive write cycles with ld_ready held at 1.
- Reset mid-operation: both buffers occupied, rst asserted for one cycle → no write on the following cycle; busy=0; both ready=1.
